// File: rtl/reg_bus_arbiter_if.sv
// Bus bundle between the requesters, the arbiter and the shared register slave.
// Handshake: a requester holds req_i and its payload until its one-cycle ack_o pulse.
interface reg_bus_arbiter_if #(
  parameter int NumReq = 2,
  parameter int RegAw  = 8,
  parameter int RegDw  = 32,
  parameter int RegBw  = RegDw / 8
);
  logic [NumReq-1:0]       req_i;
  logic [NumReq-1:0]       write_i;
  logic [NumReq*RegAw-1:0] addr_i;
  logic [NumReq*RegDw-1:0] wdata_i;
  logic [NumReq*RegBw-1:0] wstrb_i;
  logic [NumReq-1:0]       ack_o;
  logic [RegDw-1:0]        rdata_o;
  logic                    error_o;
  logic                    busy_o;
  logic                    re_o;
  logic                    we_o;
  logic [RegAw-1:0]        addr_o;
  logic [RegDw-1:0]        wdata_o;
  logic [RegBw-1:0]        wstrb_o;
  logic [RegDw-1:0]        rdata_i;
  logic                    error_i;
  logic [1:0]              state_o;

  modport master (
    input  req_i, write_i, addr_i, wdata_i, wstrb_i, rdata_i, error_i,
    output ack_o, rdata_o, error_o, busy_o, re_o, we_o, addr_o, wdata_o, wstrb_o,
    output state_o
  );

  modport slave (
    output req_i, write_i, addr_i, wdata_i, wstrb_i, rdata_i, error_i,
    input  ack_o, rdata_o, error_o, busy_o, re_o, we_o, addr_o, wdata_o, wstrb_o,
    input  state_o
  );
endinterface

// File: rtl/reg_bus_arbiter.sv
// Round-robin arbiter sharing one zero-wait-state register slave between NumReq requesters.
// One transaction is IDLE (grant) -> ACCESS (re/we) -> RESP (ack); all bus outputs are registered.
module reg_bus_arbiter #(
  parameter int NumReq = 2,
  parameter int RegAw  = 8,
  parameter int RegDw  = 32,
  parameter int RegBw  = RegDw / 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  reg_bus_arbiter_if.master  bus
);

  if (NumReq < 1 || NumReq > 8) begin : g_bad_numreq
    $error("reg_bus_arbiter: NumReq must be in 1..8");
  end

  localparam int IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam logic [RegAw-1:0] AddrMask = ~RegAw'(3);
  localparam logic [IdxW-1:0]  LastIdx  = IdxW'(NumReq - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  state_e            state_q;
  logic [IdxW-1:0]   rr_q;
  logic [IdxW-1:0]   idx_q;
  logic              re_q;
  logic              we_q;
  logic [RegAw-1:0]  addr_q;
  logic [RegDw-1:0]  wdata_q;
  logic [RegBw-1:0]  wstrb_q;
  logic [NumReq-1:0] ack_q;
  logic [RegDw-1:0]  rdata_q;
  logic              err_q;

  logic              gnt_vld;
  logic [IdxW-1:0]   gnt_idx;
  logic [IdxW-1:0]   cand_idx;
  int                cand;

  // First requester at or above the round-robin pointer, wrapping modulo NumReq.
  always_comb begin
    gnt_vld  = 1'b0;
    gnt_idx  = '0;
    cand     = 0;
    cand_idx = '0;
    for (int i = 0; i < NumReq; i++) begin
      cand = int'(rr_q) + i;
      if (cand >= NumReq) cand = cand - NumReq;
      cand_idx = IdxW'(cand);
      if (!gnt_vld && bus.req_i[cand_idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand_idx;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      rr_q    <= '0;
      idx_q   <= '0;
      re_q    <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      ack_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt_vld) begin
            state_q <= ACCESS;
            idx_q   <= gnt_idx;
            re_q    <= ~bus.write_i[gnt_idx];
            we_q    <= bus.write_i[gnt_idx];
            addr_q  <= bus.addr_i[int'(gnt_idx)*RegAw +: RegAw] & AddrMask;
            wdata_q <= bus.wdata_i[int'(gnt_idx)*RegDw +: RegDw];
            wstrb_q <= bus.wstrb_i[int'(gnt_idx)*RegBw +: RegBw];
          end
        end
        ACCESS: begin
          state_q <= RESP;
          re_q    <= 1'b0;
          we_q    <= 1'b0;
          addr_q  <= '0;
          wdata_q <= '0;
          wstrb_q <= '0;
          ack_q   <= NumReq'(1) << idx_q;
          rdata_q <= we_q ? '0 : bus.rdata_i;
          err_q   <= bus.error_i;
        end
        RESP: begin
          state_q <= IDLE;
          ack_q   <= '0;
          rdata_q <= '0;
          err_q   <= 1'b0;
          rr_q    <= (idx_q == LastIdx) ? '0 : idx_q + 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.re_o    = re_q;
  assign bus.we_o    = we_q;
  assign bus.addr_o  = addr_q;
  assign bus.wdata_o = wdata_q;
  assign bus.wstrb_o = wstrb_q;
  assign bus.ack_o   = ack_q;
  assign bus.rdata_o = rdata_q;
  assign bus.error_o = err_q;
  assign bus.busy_o  = (state_q != IDLE);
  assign bus.state_o = state_q;

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Directed bench for reg_bus_arbiter (NumReq=2): reset, read, write, round-robin order,
// error reporting, dropped request and mid-transaction reset.
module tb_reg_bus_arbiter;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;
  logic [1:0] exp_q[$];

  reg_bus_arbiter_if #(.NumReq(2), .RegAw(8), .RegDw(32), .RegBw(4)) bus ();

  reg_bus_arbiter #(.NumReq(2), .RegAw(8), .RegDw(32), .RegBw(4)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.req_i   = '0;
    bus.write_i = '0;
    bus.addr_i  = '0;
    bus.wdata_i = '0;
    bus.wstrb_i = '0;
    bus.rdata_i = '0;
    bus.error_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_idle();
    tick();
    tick();
    vectors++; if (bus.ack_o !== 2'b00) begin miscompares++; $display("FAIL reset_ack: got %b want 00", bus.ack_o); end
    vectors++; if (bus.rdata_o !== 32'h0) begin miscompares++; $display("FAIL reset_rdata: got %h want 0", bus.rdata_o); end
    vectors++; if (bus.error_o !== 1'b0) begin miscompares++; $display("FAIL reset_error: got %b want 0", bus.error_o); end
    vectors++; if (bus.busy_o !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", bus.busy_o); end
    vectors++; if (bus.re_o !== 1'b0 || bus.we_o !== 1'b0) begin miscompares++; $display("FAIL reset_re_we: got %b%b want 00", bus.re_o, bus.we_o); end
    vectors++; if (bus.addr_o !== 8'h0) begin miscompares++; $display("FAIL reset_addr: got %h want 0", bus.addr_o); end
    vectors++; if (bus.wdata_o !== 32'h0 || bus.wstrb_o !== 4'h0) begin miscompares++; $display("FAIL reset_wdata_wstrb: got %h/%h want 0/0", bus.wdata_o, bus.wstrb_o); end
    vectors++; if (bus.state_o !== 2'd0) begin miscompares++; $display("FAIL reset_state: got %0d want 0", bus.state_o); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_read();
    bus.write_i      = 2'b00;
    bus.addr_i[7:0]  = 8'h13;
    bus.rdata_i      = 32'hDEADBEEF;
    bus.error_i      = 1'b0;
    bus.req_i        = 2'b01;
    tick();
    vectors++; if (bus.re_o !== 1'b1 || bus.we_o !== 1'b0) begin miscompares++; $display("FAIL read_re_we: got %b%b want 10", bus.re_o, bus.we_o); end
    vectors++; if (bus.addr_o !== 8'h10) begin miscompares++; $display("FAIL read_addr: got %h want 10", bus.addr_o); end
    vectors++; if (bus.busy_o !== 1'b1 || bus.ack_o !== 2'b00) begin miscompares++; $display("FAIL read_access_busy_ack: got %b/%b want 1/00", bus.busy_o, bus.ack_o); end
    tick();
    vectors++; if (bus.ack_o !== 2'b01) begin miscompares++; $display("FAIL read_ack: got %b want 01", bus.ack_o); end
    vectors++; if (bus.rdata_o !== 32'hDEADBEEF) begin miscompares++; $display("FAIL read_rdata: got %h want deadbeef", bus.rdata_o); end
    vectors++; if (bus.error_o !== 1'b0 || bus.busy_o !== 1'b1) begin miscompares++; $display("FAIL read_resp_err_busy: got %b/%b want 0/1", bus.error_o, bus.busy_o); end
    vectors++; if (bus.re_o !== 1'b0 || bus.addr_o !== 8'h0) begin miscompares++; $display("FAIL read_resp_re_addr: got %b/%h want 0/00", bus.re_o, bus.addr_o); end
    bus.req_i = 2'b00;
    tick();
    vectors++; if (bus.busy_o !== 1'b0 || bus.ack_o !== 2'b00 || bus.rdata_o !== 32'h0) begin miscompares++; $display("FAIL read_idle: got busy %b ack %b rdata %h want 0/00/0", bus.busy_o, bus.ack_o, bus.rdata_o); end
  endtask

  task automatic test_write();
    bus.write_i       = 2'b10;
    bus.addr_i[15:8]  = 8'h24;
    bus.wdata_i[63:32] = 32'hA5A50F0F;
    bus.wstrb_i[7:4]  = 4'b0101;
    bus.rdata_i       = 32'h12345678;
    bus.req_i         = 2'b10;
    tick();
    vectors++; if (bus.we_o !== 1'b1 || bus.re_o !== 1'b0) begin miscompares++; $display("FAIL write_we_re: got %b%b want 10", bus.we_o, bus.re_o); end
    vectors++; if (bus.addr_o !== 8'h24) begin miscompares++; $display("FAIL write_addr: got %h want 24", bus.addr_o); end
    vectors++; if (bus.wdata_o !== 32'hA5A50F0F) begin miscompares++; $display("FAIL write_wdata: got %h want a5a50f0f", bus.wdata_o); end
    vectors++; if (bus.wstrb_o !== 4'h5) begin miscompares++; $display("FAIL write_wstrb: got %h want 5", bus.wstrb_o); end
    tick();
    vectors++; if (bus.we_o !== 1'b0 || bus.wdata_o !== 32'h0 || bus.wstrb_o !== 4'h0) begin miscompares++; $display("FAIL write_one_cycle: got we %b wdata %h wstrb %h want 0/0/0", bus.we_o, bus.wdata_o, bus.wstrb_o); end
    vectors++; if (bus.ack_o !== 2'b10) begin miscompares++; $display("FAIL write_ack: got %b want 10", bus.ack_o); end
    vectors++; if (bus.rdata_o !== 32'h0) begin miscompares++; $display("FAIL write_rdata: got %h want 0", bus.rdata_o); end
    bus.req_i   = 2'b00;
    bus.write_i = 2'b00;
    tick();
    vectors++; if (bus.ack_o !== 2'b00 || bus.busy_o !== 1'b0) begin miscompares++; $display("FAIL write_idle: got ack %b busy %b want 00/0", bus.ack_o, bus.busy_o); end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_ack;
    logic [7:0] exp_addr;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.write_i      = 2'b00;
    bus.addr_i[7:0]  = 8'h40;
    bus.addr_i[15:8] = 8'h80;
    bus.rdata_i      = 32'h11111111;
    exp_q.push_back(2'b01);
    exp_q.push_back(2'b10);
    exp_q.push_back(2'b01);
    exp_q.push_back(2'b10);
    bus.req_i = 2'b11;
    for (int t = 0; t < 4; t++) begin
      exp_ack  = exp_q.pop_front();
      exp_addr = (exp_ack == 2'b01) ? 8'h40 : 8'h80;
      tick();
      vectors++; if (bus.re_o !== 1'b1 || bus.addr_o !== exp_addr) begin miscompares++; $display("FAIL rr_access[%0d]: got re %b addr %h want 1/%h", t, bus.re_o, bus.addr_o, exp_addr); end
      tick();
      vectors++; if (bus.ack_o !== exp_ack) begin miscompares++; $display("FAIL rr_ack[%0d]: got %b want %b", t, bus.ack_o, exp_ack); end
      tick();
      vectors++; if (bus.ack_o !== 2'b00 || bus.re_o !== 1'b0) begin miscompares++; $display("FAIL rr_gap[%0d]: got ack %b re %b want 00/0", t, bus.ack_o, bus.re_o); end
    end
    bus.req_i = 2'b00;
    tick();
    vectors++; if (bus.state_o !== 2'd0 || bus.busy_o !== 1'b0) begin miscompares++; $display("FAIL rr_end_idle: got state %0d busy %b want 0/0", bus.state_o, bus.busy_o); end
  endtask

  task automatic test_error();
    bus.write_i     = 2'b00;
    bus.addr_i[7:0] = 8'h0C;
    bus.rdata_i     = 32'hCAFEF00D;
    bus.error_i     = 1'b1;
    bus.req_i       = 2'b01;
    tick();
    vectors++; if (bus.re_o !== 1'b1) begin miscompares++; $display("FAIL err_access_re: got %b want 1", bus.re_o); end
    tick();
    vectors++; if (bus.ack_o !== 2'b01 || bus.error_o !== 1'b1) begin miscompares++; $display("FAIL err_ack: got ack %b err %b want 01/1", bus.ack_o, bus.error_o); end
    vectors++; if (bus.rdata_o !== 32'hCAFEF00D) begin miscompares++; $display("FAIL err_rdata: got %h want cafef00d", bus.rdata_o); end
    bus.req_i   = 2'b00;
    bus.error_i = 1'b0;
    tick();
    vectors++; if (bus.error_o !== 1'b0) begin miscompares++; $display("FAIL err_idle: got %b want 0", bus.error_o); end
    bus.req_i = 2'b01;
    tick();
    tick();
    vectors++; if (bus.ack_o !== 2'b01 || bus.error_o !== 1'b0) begin miscompares++; $display("FAIL err_clear: got ack %b err %b want 01/0", bus.ack_o, bus.error_o); end
    bus.req_i = 2'b00;
    tick();
  endtask

  task automatic test_drop();
    bus.write_i     = 2'b00;
    bus.addr_i[7:0] = 8'h0C;
    bus.rdata_i     = 32'h0BADF00D;
    bus.req_i       = 2'b01;
    tick();
    bus.req_i = 2'b00;
    vectors++; if (bus.re_o !== 1'b1 || bus.addr_o !== 8'h0C) begin miscompares++; $display("FAIL drop_access: got re %b addr %h want 1/0c", bus.re_o, bus.addr_o); end
    tick();
    vectors++; if (bus.ack_o !== 2'b01 || bus.rdata_o !== 32'h0BADF00D) begin miscompares++; $display("FAIL drop_ack: got ack %b rdata %h want 01/0badf00d", bus.ack_o, bus.rdata_o); end
    tick();
    tick();
    vectors++; if (bus.re_o !== 1'b0 || bus.we_o !== 1'b0 || bus.busy_o !== 1'b0) begin miscompares++; $display("FAIL drop_no_second: got re %b we %b busy %b want 0/0/0", bus.re_o, bus.we_o, bus.busy_o); end
    tick();
    vectors++; if (bus.ack_o !== 2'b00 || bus.busy_o !== 1'b0) begin miscompares++; $display("FAIL drop_quiet: got ack %b busy %b want 00/0", bus.ack_o, bus.busy_o); end
  endtask

  task automatic test_reset_mid();
    bus.write_i      = 2'b00;
    bus.addr_i[7:0]  = 8'h40;
    bus.addr_i[15:8] = 8'h80;
    bus.rdata_i      = 32'h55AA55AA;
    bus.req_i        = 2'b10;
    tick();
    vectors++; if (bus.re_o !== 1'b1 || bus.addr_o !== 8'h80) begin miscompares++; $display("FAIL rstmid_access: got re %b addr %h want 1/80", bus.re_o, bus.addr_o); end
    #1;
    rst = 1'b1;
    #1;
    vectors++; if (bus.re_o !== 1'b0 || bus.addr_o !== 8'h0) begin miscompares++; $display("FAIL rstmid_re_async: got re %b addr %h want 0/00", bus.re_o, bus.addr_o); end
    vectors++; if (bus.busy_o !== 1'b0 || bus.ack_o !== 2'b00) begin miscompares++; $display("FAIL rstmid_busy_ack: got busy %b ack %b want 0/00", bus.busy_o, bus.ack_o); end
    tick();
    vectors++; if (bus.ack_o !== 2'b00) begin miscompares++; $display("FAIL rstmid_no_ack: got %b want 00", bus.ack_o); end
    rst = 1'b0;
    bus.req_i = 2'b11;
    tick();
    vectors++; if (bus.re_o !== 1'b1 || bus.addr_o !== 8'h40) begin miscompares++; $display("FAIL rstmid_regrant: got re %b addr %h want 1/40", bus.re_o, bus.addr_o); end
    tick();
    vectors++; if (bus.ack_o !== 2'b01) begin miscompares++; $display("FAIL rstmid_ack: got %b want 01", bus.ack_o); end
    bus.req_i = 2'b00;
    tick();
    tick();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    drive_idle();
    test_reset();
    test_read();
    test_write();
    test_round_robin();
    test_error();
    test_drop();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
